alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter FUNCT_W, default 6, SHALL set the width of funct_i and alu_func_o.
REQ-002 Parameter MUL_LAT, default 4, range 1..63, SHALL set the multiply busy-cycle count.
REQ-003 Parameter DIV_LAT, default 32, range 1..63, SHALL set the divide busy-cycle count.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 valid_i  input  1  EX-stage instruction present and issuing this cycle.
REQ-007 flush_i  input  1  kill the EX instruction and any multi-cycle operation.
REQ-008 alu_op_i  input  2  ALUOp from the main control unit.
REQ-009 funct_i  input  FUNCT_W  instruction funct field.
REQ-010 alu_func_o  output  FUNCT_W  registered ALU function code.
REQ-011 md_start_o  output  1  one-cycle start pulse to the mult/div unit.
REQ-012 stall_o  output  1  hold IF/ID/EX to the hazard unit.
REQ-013 hilo_we_o  output  1  one-cycle HI/LO write enable at operation completion.

Function
REQ-014 Decode: ALUOp 00 -> 001001 (addu); 01 -> 001010 (subu); 11 -> 010010 (or); 10 -> funct decode.
REQ-015 Funct decode: 001011 -> 001001; 001101 -> 001010; 010010 -> 010001; 100110 -> 100001; 011000 -> 011001 (mult); 011010 -> 011010 (div); any other -> 0.
REQ-016 alu_func_o SHALL load the decoded code on each edge with valid_i=1, stall_o=0 and flush_i=0.
REQ-017 alu_func_o SHALL load 0 (bubble) on an edge with valid_i=0 or flush_i=1, and SHALL hold its value while stall_o=1.
REQ-018 FSM states SHALL be IDLE, MUL, DIV and DONE; stall_o=1 exactly in MUL and DIV.
REQ-019 IDLE -> MUL on accepted mult (REQ-016 conditions); counter loads MUL_LAT-1; md_start_o=1 for the following cycle only.
REQ-020 IDLE -> DIV on accepted div; counter loads DIV_LAT-1; md_start_o=1 for the following cycle only.
REQ-021 In MUL or DIV the counter SHALL decrement each cycle; at count 0 the next state SHALL be DONE, so stall_o is high for exactly LAT cycles.
REQ-022 DONE SHALL last one cycle with hilo_we_o=1 and stall_o=0, then return to IDLE, or accept a new instruction per REQ-016, REQ-019 and REQ-020.
REQ-023 valid_i, alu_op_i and funct_i SHALL be ignored while stall_o=1.
REQ-024 flush_i=1 SHALL force IDLE on the next edge from any state, clear the counter, and suppress hilo_we_o and md_start_o.
REQ-025 flush_i takes priority over a simultaneous valid_i.
REQ-026 Counter width SHALL be 6 bits, sufficient for LAT-1 up to 62.

Reset
REQ-027 On rst=1, immediately and independent of clk: state=IDLE, counter=0, alu_func_o=0, md_start_o=0, stall_o=0, hilo_we_o=0.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no hilo_we_o pulse.
REQ-029 The first accepted instruction after release SHALL be decoded normally on the first rising edge with rst=0.

Configuration
REQ-030 With macro ALU_SEQ_DIV_EN defined, divide SHALL behave per REQ-015, REQ-020 and REQ-021.
REQ-031 Without ALU_SEQ_DIV_EN, funct 011010 SHALL decode to 0, no DIV state entry occurs, stall_o stays 0, and DIV_LAT is unused.

Verification
REQ-032 ALUOp=10, funct=001011, valid=1 -> alu_func_o=001001 next cycle; stall_o=0.
REQ-033 mult issued, MUL_LAT=4 -> md_start_o=1 for 1 cycle, stall_o=1 for 4 cycles, then hilo_we_o=1 for 1 cycle, alu_func_o held at 011001 throughout.
REQ-034 div issued with ALU_SEQ_DIV_EN, DIV_LAT=32 -> stall_o=1 for 32 cycles, then hilo_we_o=1; without the macro -> alu_func_o=0 and stall_o=0.
REQ-035 flush_i=1 in cycle 2 of a mult -> IDLE next cycle, stall_o=0, no hilo_we_o, alu_func_o=0.
REQ-036 rst pulse mid-divide between clock edges -> all outputs 0 immediately; a following addu (ALUOp=00) gives 001001.
REQ-037 valid_i=1 with funct=111111 and ALUOp=10 -> alu_func_o=0; ALUOp=11 -> 010010.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: EX-stage ALU function decoder and mult/div sequencer.
// Decodes ALUOp/funct into a registered ALU function code. For mult (and
// div when enabled) it drives the start pulse, holds the pipeline with
// stall_o for the operation latency, and then pulses hilo_we_o for one cycle.
// Optional feature: define ALU_SEQ_DIV_EN to enable the divide path. Without
// it, funct 011010 decodes to 0 and DIV_LAT has no effect.
module alu_op_sequencer #(
    parameter int FUNCT_W = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [1:0]         alu_op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [FUNCT_W-1:0] alu_func_o,
    output logic               md_start_o,
    output logic               stall_o,
    output logic               hilo_we_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter preloads: LAT-1 so the busy phase spans exactly LAT cycles.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT - 1);

    localparam logic [FUNCT_W-1:0] FN_MULT = FUNCT_W'(6'b011001);

    state_t             state;
    logic [5:0]         cnt;
    logic [FUNCT_W-1:0] dec_p0;
    logic               is_mul_p0;
    logic               is_div_p0;

    // ALUOp/funct to ALU function code; anything unrecognised is a bubble (0).
    function automatic logic [FUNCT_W-1:0] decode_op(input logic [1:0]         op,
                                                     input logic [FUNCT_W-1:0] f);
        logic [FUNCT_W-1:0] r;
        r = '0;
        case (op)
            2'b00: r = FUNCT_W'(6'b001001);
            2'b01: r = FUNCT_W'(6'b001010);
            2'b11: r = FUNCT_W'(6'b010010);
            default: begin
                case (f)
                    FUNCT_W'(6'b001011): r = FUNCT_W'(6'b001001);
                    FUNCT_W'(6'b001101): r = FUNCT_W'(6'b001010);
                    FUNCT_W'(6'b010010): r = FUNCT_W'(6'b010001);
                    FUNCT_W'(6'b100110): r = FUNCT_W'(6'b100001);
                    FUNCT_W'(6'b011000): r = FN_MULT;
`ifdef ALU_SEQ_DIV_EN
                    FUNCT_W'(6'b011010): r = FUNCT_W'(6'b011010);
`endif
                    default:             r = '0;
                endcase
            end
        endcase
        return r;
    endfunction

    // Decode the incoming instruction and classify multi-cycle operations.
    always_comb begin
        dec_p0    = decode_op(alu_op_i, funct_i);
        is_mul_p0 = (dec_p0 == FN_MULT);
`ifdef ALU_SEQ_DIV_EN
        is_div_p0 = (dec_p0 == FUNCT_W'(6'b011010));
`else
        is_div_p0 = 1'b0;
`endif
    end

    // Sequencer FSM with registered outputs; flush overrides everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_func_o <= '0;
            md_start_o <= 1'b0;
            stall_o    <= 1'b0;
            hilo_we_o  <= 1'b0;
        end else if (flush_i) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_func_o <= '0;
            md_start_o <= 1'b0;
            stall_o    <= 1'b0;
            hilo_we_o  <= 1'b0;
        end else begin
            case (state)
                MUL, DIV: begin
                    md_start_o <= 1'b0;
                    if (cnt == 6'd0) begin
                        state     <= DONE;
                        stall_o   <= 1'b0;
                        hilo_we_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: begin
                    hilo_we_o <= 1'b0;
                    if (valid_i) begin
                        alu_func_o <= dec_p0;
                        if (is_mul_p0 || is_div_p0) begin
                            state      <= is_mul_p0 ? MUL : DIV;
                            cnt        <= is_mul_p0 ? MUL_LOAD : DIV_LOAD;
                            md_start_o <= 1'b1;
                            stall_o    <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            md_start_o <= 1'b0;
                            stall_o    <= 1'b0;
                        end
                    end else begin
                        alu_func_o <= '0;
                        state      <= IDLE;
                        md_start_o <= 1'b0;
                        stall_o    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
